// File: rtl/pipeline_ctrl_unit.sv
`default_nettype none
// ============================================================================
// pipeline_ctrl_unit : MIPS-style decode, forwarding/hazard control and
//                      ex/mem/wb control pipeline registers.
// Revision 1.0
// ============================================================================
module pipeline_ctrl_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instruction,
  input  logic [4:0]  i_rw_ex,
  input  logic [4:0]  i_rw_mem,
  input  logic [4:0]  i_rw_w,
  input  logic        i_overflow,
  input  logic        i_interrupt,
  output logic        o_RegDst,
  output logic        o_ExtOp,
  output logic        o_ALUSrc,
  output logic        o_J,
  output logic        o_Jr,
  output logic        o_Beq,
  output logic        o_Bne,
  output logic [1:0]  o_ASrc,
  output logic [1:0]  o_BSrc,
  output logic        o_stall,
  output logic        o_invalid_instr,
  output logic [10:0] o_ALUCtrl,
  output logic        o_mc0,
  output logic        o_coproc0_we,
  output logic        o_eret,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_MemtoReg,
  output logic        o_RegWr
);

  localparam logic [10:0] ALU_ADD = 11'h001;
  localparam logic [10:0] ALU_SUB = 11'h002;
  localparam logic [10:0] ALU_AND = 11'h004;
  localparam logic [10:0] ALU_OR  = 11'h008;
  localparam logic [10:0] ALU_XOR = 11'h010;
  localparam logic [10:0] ALU_NOR = 11'h020;
  localparam logic [10:0] ALU_SLT = 11'h040;
  localparam logic [10:0] ALU_SLL = 11'h080;
  localparam logic [10:0] ALU_SRL = 11'h100;
  localparam logic [10:0] ALU_SRA = 11'h200;
  localparam logic [10:0] ALU_LUI = 11'h400;

  typedef struct packed {
    logic [10:0] alu;
    logic        regwr;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        mc0;
    logic        cp0we;
    logic        eret;
    logic        ovf_trap;
  } ex_ctrl_t;

  typedef struct packed {
    logic regwr;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } mem_ctrl_t;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;

  assign op    = i_instruction[31:26];
  assign funct = i_instruction[5:0];
  assign rs    = i_instruction[25:21];
  assign rt    = i_instruction[20:16];

  ex_ctrl_t  dec_ctrl, ex_d, ex_q;
  mem_ctrl_t mem_d, mem_q;
  logic      wb_regwr_q;
  logic      valid, reads_rs, reads_rt;
  logic      regdst, extop, alusrc, jmp, jr, beq, bne;
  logic      fwd_ex, fwd_mem, fwd_wb, load_use;

  always_comb begin
    dec_ctrl = '0;
    regdst   = 1'b0;
    extop    = 1'b0;
    alusrc   = 1'b0;
    jmp      = 1'b0;
    jr       = 1'b0;
    beq      = 1'b0;
    bne      = 1'b0;
    valid    = 1'b1;
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    case (op)
      6'h00: begin
        regdst         = 1'b1;
        dec_ctrl.regwr = 1'b1;
        reads_rs       = 1'b1;
        reads_rt       = 1'b1;
        case (funct)
          6'h20: begin dec_ctrl.alu = ALU_ADD; dec_ctrl.ovf_trap = 1'b1; end
          6'h21: dec_ctrl.alu = ALU_ADD;
          6'h22: begin dec_ctrl.alu = ALU_SUB; dec_ctrl.ovf_trap = 1'b1; end
          6'h23: dec_ctrl.alu = ALU_SUB;
          6'h24: dec_ctrl.alu = ALU_AND;
          6'h25: dec_ctrl.alu = ALU_OR;
          6'h26: dec_ctrl.alu = ALU_XOR;
          6'h27: dec_ctrl.alu = ALU_NOR;
          6'h2A: dec_ctrl.alu = ALU_SLT;
          6'h00: begin dec_ctrl.alu = ALU_SLL; reads_rs = 1'b0; end
          6'h02: begin dec_ctrl.alu = ALU_SRL; reads_rs = 1'b0; end
          6'h03: begin dec_ctrl.alu = ALU_SRA; reads_rs = 1'b0; end
          6'h08: begin jr = 1'b1; dec_ctrl.regwr = 1'b0; reads_rt = 1'b0; end
          default: valid = 1'b0;
        endcase
      end
      6'h08: begin
        dec_ctrl.alu = ALU_ADD; dec_ctrl.ovf_trap = 1'b1; dec_ctrl.regwr = 1'b1;
        extop = 1'b1; alusrc = 1'b1; reads_rs = 1'b1;
      end
      6'h09: begin
        dec_ctrl.alu = ALU_ADD; dec_ctrl.regwr = 1'b1;
        extop = 1'b1; alusrc = 1'b1; reads_rs = 1'b1;
      end
      6'h0C: begin dec_ctrl.alu = ALU_AND; dec_ctrl.regwr = 1'b1; alusrc = 1'b1; reads_rs = 1'b1; end
      6'h0D: begin dec_ctrl.alu = ALU_OR;  dec_ctrl.regwr = 1'b1; alusrc = 1'b1; reads_rs = 1'b1; end
      6'h0E: begin dec_ctrl.alu = ALU_XOR; dec_ctrl.regwr = 1'b1; alusrc = 1'b1; reads_rs = 1'b1; end
      6'h0A: begin
        dec_ctrl.alu = ALU_SLT; dec_ctrl.regwr = 1'b1;
        extop = 1'b1; alusrc = 1'b1; reads_rs = 1'b1;
      end
      6'h0F: begin dec_ctrl.alu = ALU_LUI; dec_ctrl.regwr = 1'b1; alusrc = 1'b1; end
      6'h23: begin
        dec_ctrl.alu = ALU_ADD; dec_ctrl.regwr = 1'b1;
        dec_ctrl.memread = 1'b1; dec_ctrl.memtoreg = 1'b1;
        extop = 1'b1; alusrc = 1'b1; reads_rs = 1'b1;
      end
      6'h2B: begin
        dec_ctrl.alu = ALU_ADD; dec_ctrl.memwrite = 1'b1;
        extop = 1'b1; alusrc = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1;
      end
      6'h04: begin beq = 1'b1; extop = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1; end
      6'h05: begin bne = 1'b1; extop = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1; end
      6'h02: jmp = 1'b1;
      6'h10: begin
        case (rs)
          5'h00: begin dec_ctrl.mc0 = 1'b1; dec_ctrl.regwr = 1'b1; end
          5'h04: begin dec_ctrl.cp0we = 1'b1; alusrc = 1'b1; reads_rt = 1'b1; end
          5'h10: begin
            if (funct == 6'h18) dec_ctrl.eret = 1'b1;
            else                valid = 1'b0;
          end
          default: valid = 1'b0;
        endcase
      end
      default: valid = 1'b0;
    endcase
    // The canonical nop (sll $0,$0,0) must not look like a register write
    if (i_instruction == 32'h0000_0000) dec_ctrl.regwr = 1'b0;
    if (!valid) begin
      dec_ctrl = '0;
      regdst   = 1'b0;
      extop    = 1'b0;
      alusrc   = 1'b0;
      jmp      = 1'b0;
      jr       = 1'b0;
      beq      = 1'b0;
      bne      = 1'b0;
      reads_rs = 1'b0;
      reads_rt = 1'b0;
    end
  end

  assign fwd_ex  = ex_q.regwr  && (i_rw_ex  != 5'd0);
  assign fwd_mem = mem_q.regwr && (i_rw_mem != 5'd0);
  assign fwd_wb  = wb_regwr_q  && (i_rw_w   != 5'd0);

  always_comb begin
    o_ASrc = 2'b00;
    if      (fwd_ex  && (i_rw_ex  == rs)) o_ASrc = 2'b01;
    else if (fwd_mem && (i_rw_mem == rs)) o_ASrc = 2'b10;
    else if (fwd_wb  && (i_rw_w   == rs)) o_ASrc = 2'b11;
  end

  always_comb begin
    o_BSrc = 2'b00;
    if      (fwd_ex  && (i_rw_ex  == rt)) o_BSrc = 2'b01;
    else if (fwd_mem && (i_rw_mem == rt)) o_BSrc = 2'b10;
    else if (fwd_wb  && (i_rw_w   == rt)) o_BSrc = 2'b11;
  end

  // Only lw sets memread, so it doubles as the "ex holds a load" flag
  assign load_use = ex_q.memread && (i_rw_ex != 5'd0) &&
                    ((reads_rs && (rs == i_rw_ex)) || (reads_rt && (rt == i_rw_ex)));

  assign o_stall = load_use && !i_interrupt;
  assign ex_d    = (i_interrupt || load_use) ? '0 : dec_ctrl;

  assign mem_d.regwr    = ex_q.regwr && !(i_overflow && ex_q.ovf_trap);
  assign mem_d.memread  = ex_q.memread;
  assign mem_d.memwrite = ex_q.memwrite;
  assign mem_d.memtoreg = ex_q.memtoreg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_regwr_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_regwr_q <= mem_q.regwr;
    end
  end

  assign o_RegDst        = regdst;
  assign o_ExtOp         = extop;
  assign o_ALUSrc        = alusrc;
  assign o_J             = jmp;
  assign o_Jr            = jr;
  assign o_Beq           = beq;
  assign o_Bne           = bne;
  assign o_invalid_instr = !valid;
  assign o_ALUCtrl       = ex_q.alu;
  assign o_mc0           = ex_q.mc0;
  assign o_coproc0_we    = ex_q.cp0we;
  assign o_eret          = ex_q.eret;
  assign o_MemRead       = mem_q.memread;
  assign o_MemWrite      = mem_q.memwrite;
  assign o_MemtoReg      = mem_q.memtoreg;
  assign o_RegWr         = wb_regwr_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl_unit.sv
`default_nettype none
// ============================================================================
// tb_pipeline_ctrl_unit : decode table vectors with a stage scoreboard, plus
//                         forwarding, hazard, interrupt, overflow and reset runs.
// Revision 1.0
// ============================================================================
module tb_pipeline_ctrl_unit;

  localparam logic [10:0] A_ADD = 11'h001;
  localparam logic [10:0] A_SUB = 11'h002;
  localparam logic [10:0] A_AND = 11'h004;
  localparam logic [10:0] A_OR  = 11'h008;
  localparam logic [10:0] A_XOR = 11'h010;
  localparam logic [10:0] A_NOR = 11'h020;
  localparam logic [10:0] A_SLT = 11'h040;
  localparam logic [10:0] A_SLL = 11'h080;
  localparam logic [10:0] A_SRL = 11'h100;
  localparam logic [10:0] A_SRA = 11'h200;
  localparam logic [10:0] A_LUI = 11'h400;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [4:0]  rw_ex, rw_mem, rw_w;
  logic        ovf, irq;
  logic        RegDst, ExtOp, ALUSrc, J, Jr, Beq, Bne;
  logic [1:0]  ASrc, BSrc;
  logic        stall, invalid;
  logic [10:0] ALUCtrl;
  logic        mc0, cp0we, eret, MemRead, MemWrite, MemtoReg, RegWr;

  pipeline_ctrl_unit dut (
    .i_clk(clk), .i_rst(rst), .i_instruction(instr),
    .i_rw_ex(rw_ex), .i_rw_mem(rw_mem), .i_rw_w(rw_w),
    .i_overflow(ovf), .i_interrupt(irq),
    .o_RegDst(RegDst), .o_ExtOp(ExtOp), .o_ALUSrc(ALUSrc), .o_J(J), .o_Jr(Jr),
    .o_Beq(Beq), .o_Bne(Bne), .o_ASrc(ASrc), .o_BSrc(BSrc), .o_stall(stall),
    .o_invalid_instr(invalid), .o_ALUCtrl(ALUCtrl), .o_mc0(mc0),
    .o_coproc0_we(cp0we), .o_eret(eret), .o_MemRead(MemRead),
    .o_MemWrite(MemWrite), .o_MemtoReg(MemtoReg), .o_RegWr(RegWr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [6:0]  dec;      // {RegDst,ExtOp,ALUSrc,J,Jr,Beq,Bne}
    logic        inv;
    logic        alu_known;
    logic [10:0] alu;
    logic [2:0]  cp;       // {mc0,coproc0_we,eret}
    logic [2:0]  mem;      // {MemRead,MemWrite,MemtoReg}
    logic        rw;
  } vec_t;

  typedef struct packed {
    logic        alu_known;
    logic [10:0] alu;
    logic [2:0]  cp;
    logic [2:0]  mem;
    logic        rw;
  } exp_t;

  vec_t vt[$];
  exp_t q_ex[$], q_mem[$], q_wb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and retire scoreboard entries stage by stage
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (q_wb.size() > 0) begin
      e = q_wb.pop_front();
      chk("wb_RegWr", 32'(RegWr), 32'(e.rw));
    end
    if (q_mem.size() > 0) begin
      e = q_mem.pop_front();
      chk("mem_ctrl", 32'({MemRead, MemWrite, MemtoReg}), 32'(e.mem));
      q_wb.push_back(e);
    end
    if (q_ex.size() > 0) begin
      e = q_ex.pop_front();
      if (e.alu_known) chk("ex_ALUCtrl", 32'(ALUCtrl), 32'(e.alu));
      chk("ex_cp0", 32'({mc0, cp0we, eret}), 32'(e.cp));
      q_mem.push_back(e);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic add_vec(input logic [31:0] ins, input logic [6:0] dec, input logic inv,
                         input logic ak, input logic [10:0] alu, input logic [2:0] cp,
                         input logic [2:0] mem, input logic rw);
    vec_t v;
    v.ins = ins; v.dec = dec; v.inv = inv; v.alu_known = ak;
    v.alu = alu; v.cp = cp; v.mem = mem; v.rw = rw;
    vt.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; instr = 32'h0; rw_ex = 5'd0; rw_mem = 5'd0; rw_w = 5'd0;
    ovf = 1'b0; irq = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    // ---------------- reset, decode stays live during reset -------------
    rst = 1'b1; instr = 32'h0022_1820; rw_ex = 5'd0; rw_mem = 5'd0; rw_w = 5'd0;
    ovf = 1'b0; irq = 1'b0;
    step(); step();
    chk("rst_regs", 32'({RegWr, MemRead, MemWrite, MemtoReg, mc0, cp0we, eret}), 32'h0);
    chk("rst_ALUCtrl", 32'(ALUCtrl), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_decode_live", 32'({RegDst, ALUSrc, invalid}), 32'b100);
    rst = 1'b0;

    // ---------------- decode table through the scoreboard ---------------
    add_vec(32'h0022_1820,                         7'b1000000, 0, 1, A_ADD, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 7'b1000000, 0, 1, A_ADD, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h22), 7'b1000000, 0, 1, A_SUB, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h23), 7'b1000000, 0, 1, A_SUB, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h24), 7'b1000000, 0, 1, A_AND, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h25), 7'b1000000, 0, 1, A_OR,  3'b000, 3'b000, 1);
    add_vec(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h26), 7'b1000000, 0, 1, A_XOR, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h27), 7'b1000000, 0, 1, A_NOR, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 7'b1000000, 0, 1, A_SLT, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd0, 5'd2, 5'd3, 5'd4, 6'h00), 7'b1000000, 0, 1, A_SLL, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd0, 5'd2, 5'd3, 5'd4, 6'h02), 7'b1000000, 0, 1, A_SRL, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd0, 5'd2, 5'd3, 5'd4, 6'h03), 7'b1000000, 0, 1, A_SRA, 3'b000, 3'b000, 1);
    add_vec(enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 7'b1000100, 0, 0, 11'h0, 3'b000, 3'b000, 0);
    add_vec(32'h0000_0000,                         7'b1000000, 0, 1, A_SLL, 3'b000, 3'b000, 0);
    add_vec(enc_i(6'h08, 5'd1, 5'd7, 16'h1),       7'b0110000, 0, 1, A_ADD, 3'b000, 3'b000, 1);
    add_vec(enc_i(6'h09, 5'd1, 5'd7, 16'h1),       7'b0110000, 0, 1, A_ADD, 3'b000, 3'b000, 1);
    add_vec(enc_i(6'h0C, 5'd1, 5'd7, 16'h1),       7'b0010000, 0, 1, A_AND, 3'b000, 3'b000, 1);
    add_vec(enc_i(6'h0D, 5'd1, 5'd7, 16'h1),       7'b0010000, 0, 1, A_OR,  3'b000, 3'b000, 1);
    add_vec(enc_i(6'h0E, 5'd1, 5'd7, 16'h1),       7'b0010000, 0, 1, A_XOR, 3'b000, 3'b000, 1);
    add_vec(enc_i(6'h0A, 5'd1, 5'd7, 16'h1),       7'b0110000, 0, 1, A_SLT, 3'b000, 3'b000, 1);
    add_vec(enc_i(6'h0F, 5'd0, 5'd7, 16'h1),       7'b0010000, 0, 1, A_LUI, 3'b000, 3'b000, 1);
    add_vec(32'h8C25_0000,                         7'b0110000, 0, 1, A_ADD, 3'b000, 3'b101, 1);
    add_vec(enc_i(6'h2B, 5'd1, 5'd5, 16'h4),       7'b0110000, 0, 1, A_ADD, 3'b000, 3'b010, 0);
    add_vec(enc_i(6'h04, 5'd1, 5'd2, 16'h3),       7'b0100010, 0, 0, 11'h0, 3'b000, 3'b000, 0);
    add_vec(enc_i(6'h05, 5'd1, 5'd2, 16'h3),       7'b0100001, 0, 0, 11'h0, 3'b000, 3'b000, 0);
    add_vec(32'h0800_0010,                         7'b0001000, 0, 0, 11'h0, 3'b000, 3'b000, 0);
    add_vec(32'h4008_6000,                         7'b0000000, 0, 0, 11'h0, 3'b100, 3'b000, 1);
    add_vec(32'h4088_6000,                         7'b0010000, 0, 0, 11'h0, 3'b010, 3'b000, 0);
    add_vec(32'h4200_0018,                         7'b0000000, 0, 0, 11'h0, 3'b001, 3'b000, 0);
    add_vec(32'hFC00_0000,                         7'b0000000, 1, 1, 11'h0, 3'b000, 3'b000, 0);
    add_vec(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 7'b0000000, 1, 1, 11'h0, 3'b000, 3'b000, 0);
    add_vec(32'h4200_0019,                         7'b0000000, 1, 1, 11'h0, 3'b000, 3'b000, 0);
    add_vec(32'h4028_6000,                         7'b0000000, 1, 1, 11'h0, 3'b000, 3'b000, 0);

    foreach (vt[i]) begin
      instr = vt[i].ins;
      #1;
      if (!vt[i].inv)
        chk($sformatf("decode[%0d]", i), 32'({RegDst, ExtOp, ALUSrc, J, Jr, Beq, Bne}), 32'(vt[i].dec));
      chk($sformatf("invalid[%0d]", i), 32'(invalid), 32'(vt[i].inv));
      chk($sformatf("nostall[%0d]", i), 32'(stall), 32'h0);
      e.alu_known = vt[i].alu_known; e.alu = vt[i].alu; e.cp = vt[i].cp;
      e.mem = vt[i].mem; e.rw = vt[i].rw;
      q_ex.push_back(e);
      step();
    end
    instr = 32'h0;
    for (int k = 0; k < 3; k++) step();

    // ---------------- forwarding priority and register 0 ----------------
    do_reset();
    instr = 32'h0022_1820; step();                    // ex: add $3
    instr = 32'h0061_2025; rw_ex = 5'd3; #1;
    chk("fwd_or_ASrc", 32'(ASrc), 32'h1);
    chk("fwd_or_BSrc", 32'(BSrc), 32'h0);
    chk("fwd_or_stall", 32'(stall), 32'h0);
    instr = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h20); step();
    instr = enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h20); step();   // ex $5, mem $4, wb $3
    rw_ex = 5'd5; rw_mem = 5'd4; rw_w = 5'd3;
    instr = enc_r(5'd3, 5'd4, 5'd9, 5'd0, 6'h25); #1;
    chk("fwd_wb_mem", 32'({ASrc, BSrc}), 32'b1110);
    instr = enc_r(5'd5, 5'd3, 5'd9, 5'd0, 6'h25); #1;
    chk("fwd_ex_wb", 32'({ASrc, BSrc}), 32'b0111);
    rw_mem = 5'd5; instr = enc_r(5'd5, 5'd5, 5'd9, 5'd0, 6'h25); #1;
    chk("fwd_ex_over_mem", 32'({ASrc, BSrc}), 32'b0101);
    rw_ex = 5'd4; rw_w = 5'd5; #1;
    chk("fwd_mem_over_wb", 32'({ASrc, BSrc}), 32'b1010);
    rw_ex = 5'd0; rw_mem = 5'd0; rw_w = 5'd0; instr = enc_r(5'd0, 5'd0, 5'd9, 5'd0, 6'h25); #1;
    chk("fwd_reg0", 32'({ASrc, BSrc}), 32'b0000);

    do_reset();
    instr = enc_i(6'h2B, 5'd1, 5'd5, 16'h0); step();        // ex: sw (no write)
    rw_ex = 5'd5; instr = enc_r(5'd5, 5'd5, 5'd9, 5'd0, 6'h20); #1;
    chk("fwd_nowrite_stage", 32'({ASrc, BSrc}), 32'b0000);
    chk("nostall_after_sw", 32'(stall), 32'h0);

    // ---------------- load-use hazard ----------------------------------
    do_reset();
    instr = 32'h8C25_0000; step();                    // ex: lw $5
    rw_ex = 5'd5; instr = 32'h00A2_3020; #1;
    chk("lu_stall", 32'(stall), 32'h1);
    instr = enc_i(6'h0F, 5'd0, 5'd5, 16'h1); #1;
    chk("lu_lui_nostall", 32'(stall), 32'h0);
    instr = enc_i(6'h2B, 5'd1, 5'd5, 16'h0); #1;
    chk("lu_sw_rt_stall", 32'(stall), 32'h1);
    instr = enc_i(6'h04, 5'd5, 5'd1, 16'h0); #1;
    chk("lu_beq_rs_stall", 32'(stall), 32'h1);
    rw_ex = 5'd0; instr = enc_r(5'd0, 5'd0, 5'd6, 5'd0, 6'h20); #1;
    chk("lu_reg0_nostall", 32'(stall), 32'h0);
    rw_ex = 5'd5; instr = 32'h00A2_3020; step();      // bubble into ex, lw to mem
    rw_ex = 5'd0; rw_mem = 5'd5; #1;
    chk("lu_bubble_ALU", 32'(ALUCtrl), 32'h0);
    chk("lu_stall_released", 32'(stall), 32'h0);
    chk("lu_ASrc_mem", 32'(ASrc), 32'h2);
    chk("lu_lw_in_mem", 32'(MemRead), 32'h1);
    step();
    chk("lu_add_in_ex", 32'(ALUCtrl), 32'(A_ADD));
    chk("lu_bubble_in_mem", 32'({MemRead, MemWrite}), 32'h0);

    // ---------------- interrupt overrides the stall --------------------
    do_reset();
    instr = 32'h8C25_0000; step();
    rw_ex = 5'd5; instr = 32'h00A2_3020; irq = 1'b1; #1;
    chk("irq_no_stall", 32'(stall), 32'h0);
    step();                                           // bubble in ex, lw in mem
    irq = 1'b0; rw_ex = 5'd0; instr = 32'h0;
    chk("irq_bubble_ALU", 32'(ALUCtrl), 32'h0);
    step();
    chk("irq_lw_in_wb", 32'(RegWr), 32'h1);
    step();
    chk("irq_bubble_in_wb", 32'(RegWr), 32'h0);

    // ---------------- overflow suppresses write-back --------------------
    do_reset();
    instr = 32'h2027_0001; step();                    // ex: addi
    ovf = 1'b1; instr = 32'h0; step(); ovf = 1'b0; step();
    chk("ovf_addi_RegWr", 32'(RegWr), 32'h0);
    instr = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h22); step();
    ovf = 1'b1; instr = 32'h0; step(); ovf = 1'b0; step();
    chk("ovf_sub_RegWr", 32'(RegWr), 32'h0);
    instr = enc_i(6'h09, 5'd1, 5'd7, 16'h1); step();
    ovf = 1'b1; instr = 32'h0; step(); ovf = 1'b0; step();
    chk("ovf_addiu_RegWr", 32'(RegWr), 32'h1);

    // ---------------- reset with a full pipe, mid-stall -----------------
    do_reset();
    instr = 32'h8C25_0000;                  step();
    instr = enc_i(6'h2B, 5'd1, 5'd2, 16'h0); step();
    instr = 32'h8C25_0000;                  step(); // ex lw, mem sw, wb lw
    rw_ex = 5'd5; instr = 32'h00A2_3020; #1;
    chk("pre_rst_full", 32'({stall, RegWr, MemWrite, ALUCtrl}), 32'({1'b1, 1'b1, 1'b1, A_ADD}));
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_full_regs", 32'({RegWr, MemRead, MemWrite, ALUCtrl}), 32'h0);
    chk("rst_full_stall", 32'(stall), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl_unit.md
PIPELINE_CTRL_UNIT -- requirements
Module: pipeline_ctrl_unit

Interface
REQ-001 The block SHALL have these ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_instruction  in  32  decode-stage instruction
- i_rw_ex, i_rw_mem, i_rw_w  in  5 each  destination register held in ex / mem / wb
- i_overflow  in  1  ALU overflow, ex stage
- i_interrupt  in  1  coproc0 interrupt taken
- o_RegDst, o_ExtOp, o_ALUSrc, o_J, o_Jr, o_Beq, o_Bne  out  1 each  decode-stage controls, combinational
- o_ASrc, o_BSrc  out  2 each  bypass select: 00 regfile, 01 ex, 10 mem, 11 wb
- o_stall  out  1  freezes PC and decode register
- o_invalid_instr  out  1  decode-stage opcode/funct not in table
- o_ALUCtrl  out  11  one-hot ALU op, ex stage
- o_mc0, o_coproc0_we, o_eret  out  1 each  ex-stage coproc0 controls
- o_MemRead, o_MemWrite, o_MemtoReg  out  1 each  mem stage
- o_RegWr  out  1  wb stage

Function
REQ-002 o_ALUCtrl bit order [10:0] SHALL be LUI, SRA, SRL, SLL, SLT, NOR, XOR, OR, AND, SUB, ADD.
REQ-003 Decode table (hex):
- R-type op 00, funct: 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 00 sll, 02 srl, 03 sra, 08 jr.
- I-type: 08/09 addi, 0C andi, 0D ori, 0E xori, 0A slti, 0F lui, 23 lw, 2B sw, 04 beq, 05 bne.
- J-type: 02 j.
- op 10: rs 00 mfc0, rs 04 mtc0, rs 10 + funct 18 eret.
- Anything else SHALL raise o_invalid_instr.
REQ-004 ExtOp SHALL be 1 for addi/addiu/slti/lw/sw/beq/bne and 0 otherwise.
REQ-005 RegDst SHALL be 1 for R-type and 0 otherwise.
REQ-006 ALUSrc SHALL be 1 for I-type ALU ops, lw, sw and mtc0.
REQ-007 Instruction 0x00000000 (sll $0) SHALL decode as a valid no-op with RegWr 0.
REQ-008 Decode controls SHALL be latched into an ex register at each clock edge. Ex controls SHALL advance to mem, and mem controls to wb, at the same edge. Latency from decode to o_ALUCtrl is 1 cycle, to o_MemRead 2 cycles, to o_RegWr 3 cycles.
REQ-009 Per-stage write-valid flags (wr_ex, wr_mem, wr_wb) SHALL be kept internally.
REQ-010 A stage is a forward source only when its flag is 1 and its i_rw_* is nonzero.
REQ-011 o_ASrc SHALL compare against rs = instr[25:21] and o_BSrc against rt = instr[20:16]. Priority SHALL be ex > mem > wb > regfile.
REQ-012 Load-use hazard: if the ex stage holds lw and a nonzero i_rw_ex equals an rs/rt the decode instruction reads, then o_stall SHALL be 1 and a bubble SHALL be latched into ex.
- A bubble is all write/mem/coproc enables 0, o_ALUCtrl 0.
- Stall lasts exactly 1 cycle per load.
REQ-013 When i_interrupt is 1, a bubble SHALL be latched into ex and o_stall SHALL be 0. Interrupt takes priority over stall.
REQ-014 An invalid instruction SHALL be latched into ex as a bubble.
REQ-015 On ex-to-mem transfer, if i_overflow is 1 and ex holds a signed add/sub/addi, then wr_mem SHALL be cleared.
REQ-016 Branches and jumps SHALL resolve in decode. The following sequential instruction executes (delay slot); no flush.
REQ-017 Register 0 SHALL never be forwarded or cause a stall.

Reset
REQ-018 While i_rst is 1 at a rising edge, all ex/mem/wb control registers SHALL clear to 0. Registered outputs SHALL read 0 in the following cycle.
REQ-019 Reset asserted mid-stall SHALL release o_stall on the next cycle.
REQ-020 Decode-stage outputs SHALL remain combinational on i_instruction during reset.

Verification
REQ-021 Sequence: add $3,$1,$2 (0x00221820), then or $4,$3,$1 (0x00612025) one cycle later -> o_ASrc=01, o_stall=0.
REQ-022 Sequence: lw $5,0($1) (0x8C250000), then add $6,$5,$2 (0x00A23020) -> o_stall=1 for one cycle; bubble in ex; then o_ASrc=10.
REQ-023 Sequence: addi $7,$1,1 (0x20270001) with i_overflow=1 in ex -> o_RegWr=0 two cycles later.
REQ-024 Decode 0xFC000000 -> o_invalid_instr=1; o_ALUCtrl=0 next cycle.
REQ-025 Hold i_interrupt=1 during a lw-use hazard -> o_stall=0; bubble latched; o_RegWr stays 0 three cycles later.
REQ-026 Assert i_rst with a valid instruction in every stage -> o_RegWr, o_MemRead, o_MemWrite, o_ALUCtrl all 0 after one edge.
